// File: rtl/dac_pkg.sv
// dac_pkg: shared state encoding and default sizing for the DAC sample scheduler.
package dac_pkg;
  localparam int DATA_W_DEF = 10;
  localparam int SPI_CYCLES_DEF = 40;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, LOAD = 2'd2, WAIT = 2'd3} state_t;
endpackage

// File: rtl/dac_sample_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; priority passes to the loser of each grant.
module rr_arb2 (
  input  logic sysclk,
  input  logic reset,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic win_b,
  output logic any
);
  logic ptr_b;
  always_comb begin
    any = req_a | req_b;
    win_b = req_b & (~req_a | ptr_b);
  end
  always_ff @(posedge sysclk) begin
    if (reset) ptr_b <= 1'b0;
    else if (en & any) ptr_b <= ~win_b;
  end
endmodule

// File: rtl/dac_sample_sched.sv
// dac_sample_sched: grants one source per sample tick, strobes the DAC load and waits out the SPI window.
module dac_sample_sched
  import dac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SPI_CYCLES = SPI_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              tick,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_load,
  output logic              busy,
  output logic              grant_b,
  output logic              overrun,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  localparam int WC_W = $clog2(SPI_CYCLES);
  localparam logic [WC_W-1:0] WAIT_LD = WC_W'(SPI_CYCLES - 1);
  state_t state, nxt;
  logic [WC_W-1:0] wcnt;
  logic win_b, any, start;
  rr_arb2 u_arb (
    .sysclk(sysclk),
    .reset(reset),
    .en(start),
    .req_a(req_a),
    .req_b(req_b),
    .win_b(win_b),
    .any(any)
  );
  always_comb begin
    nxt = state;
    start = (state == IDLE) & tick & any;
    case (state)
      IDLE:    nxt = start ? GRANT : IDLE;
      GRANT:   nxt = LOAD;
      LOAD:    nxt = WAIT;
      default: nxt = (wcnt == WC_W'(1)) ? IDLE : WAIT;
    endcase
    busy = state != IDLE;
    // strobes are masked while reset is asserted so an aborted transfer emits nothing
    ack_a = (state == GRANT) & ~grant_b & ~reset;
    ack_b = (state == GRANT) & grant_b & ~reset;
    dac_load = (state == LOAD) & ~reset;
  end
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state <= IDLE;
      wcnt <= '0;
      dac_data <= '0;
      grant_b <= 1'b0;
      overrun <= 1'b0;
      sample_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      state <= nxt;
      if (start) begin
        dac_data <= win_b ? data_b : data_a;
        grant_b <= win_b;
      end
      if (state == LOAD) begin
        sample_cnt <= sample_cnt + 1'b1;
        wcnt <= WAIT_LD;
      end else if (state == WAIT) wcnt <= wcnt - 1'b1;
      if (tick & busy) overrun <= 1'b1;
      if ((state == IDLE) & tick & ~any & ~&miss_cnt) miss_cnt <= miss_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_dac_sample_sched.sv
// tb_dac_sample_sched: timeline model of the scheduler checked every cycle, plus literal spot checks.
module tb_dac_sample_sched;
  localparam int SPI = 40;
  logic sysclk = 0, reset = 1, tick = 0, req_a = 0, req_b = 0;
  logic [9:0] data_a = 0, data_b = 0;
  logic ack_a, ack_b, dac_load, busy, grant_b, overrun;
  logic [9:0] dac_data;
  logic [15:0] sample_cnt, miss_cnt;
  logic ack_a2, ack_b2, dac_load2, busy2, grant_b2, overrun2;
  logic [9:0] dac_data2;
  logic [1:0] sample_cnt2, miss_cnt2;
  dac_sample_sched #(.DATA_W(10), .SPI_CYCLES(SPI), .CNT_W(16)) dut (
    .sysclk(sysclk), .reset(reset), .tick(tick), .req_a(req_a), .data_a(data_a),
    .req_b(req_b), .data_b(data_b), .ack_a(ack_a), .ack_b(ack_b), .dac_data(dac_data),
    .dac_load(dac_load), .busy(busy), .grant_b(grant_b), .overrun(overrun),
    .sample_cnt(sample_cnt), .miss_cnt(miss_cnt)
  );
  dac_sample_sched #(.DATA_W(10), .SPI_CYCLES(SPI), .CNT_W(2)) dut2 (
    .sysclk(sysclk), .reset(reset), .tick(tick), .req_a(req_a), .data_a(data_a),
    .req_b(req_b), .data_b(data_b), .ack_a(ack_a2), .ack_b(ack_b2), .dac_data(dac_data2),
    .dac_load(dac_load2), .busy(busy2), .grant_b(grant_b2), .overrun(overrun2),
    .sample_cnt(sample_cnt2), .miss_cnt(miss_cnt2)
  );
  always #10 sysclk = ~sysclk;
  int compared = 0, mismatched = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // model: a grant at cycle t0 gives ack at t0+1, load at t0+2, busy over t0+1..t0+1+SPI
  int n = 0, t0 = -1000, samples = 0, misses = 0;
  int last_tick = 0, last_ack = 0, last_load = 0, last_fall = 0;
  bit prio_b = 0, m_ov = 0, m_gb = 0, busy_q = 0;
  logic [9:0] m_data = 0;
  always @(negedge sysclk) begin
    int d;
    bit e_busy, win;
    d = n - t0;
    e_busy = d >= 1 && d <= SPI + 1;
    chk("busy", 32'(busy), 32'(e_busy));
    chk("ack_a", 32'(ack_a), 32'(d == 1 && !m_gb && !reset));
    chk("ack_b", 32'(ack_b), 32'(d == 1 && m_gb && !reset));
    chk("dac_load", 32'(dac_load), 32'(d == 2 && !reset));
    chk("dac_data", 32'(dac_data), 32'(m_data));
    chk("grant_b", 32'(grant_b), 32'(m_gb));
    chk("overrun", 32'(overrun), 32'(m_ov));
    chk("sample_cnt", 32'(sample_cnt), 32'(samples % 65536));
    chk("miss_cnt", 32'(miss_cnt), 32'(misses > 65535 ? 65535 : misses));
    chk("dac_load_w2", 32'(dac_load2), 32'(d == 2 && !reset));
    chk("dac_data_w2", 32'(dac_data2), 32'(m_data));
    chk("sample_cnt_w2", 32'(sample_cnt2), 32'(samples % 4));
    chk("miss_cnt_w2", 32'(miss_cnt2), 32'(misses > 3 ? 3 : misses));
    if (tick) last_tick = n;
    if (ack_a || ack_b) last_ack = n;
    if (dac_load) last_load = n;
    if (busy_q && !busy) last_fall = n;
    busy_q = busy;
    if (reset) begin
      t0 = -1000; prio_b = 0; m_ov = 0; m_gb = 0; m_data = 0; samples = 0; misses = 0;
    end else begin
      if (d == 2) samples++;
      if (tick) begin
        if (e_busy) m_ov = 1;
        else if (req_a || req_b) begin
          win = req_b && (!req_a || prio_b);
          prio_b = !win;
          m_gb = win;
          m_data = win ? data_b : data_a;
          t0 = n;
        end else misses++;
      end
    end
    n++;
  end
  task automatic cyc(input int k);
    repeat (k) @(posedge sysclk);
    #1;
  endtask
  task automatic pulse_tick();
    tick = 1;
    cyc(1);
    tick = 0;
  endtask
  task automatic do_reset();
    reset = 1;
    cyc(2);
    reset = 0;
  endtask
  logic [9:0] alt_seq [4] = '{10'h100, 10'h200, 10'h100, 10'h200};
  initial begin
    cyc(3);
    reset = 0;
    chk("reset_sample_cnt", 32'(sample_cnt), 0);
    req_a = 1; data_a = 10'h2A5;
    pulse_tick();
    cyc(1);
    req_a = 0;
    cyc(50);
    chk("lat_ack", 32'(last_ack - last_tick), 1);
    chk("lat_load", 32'(last_load - last_tick), 2);
    chk("lat_busy_fall", 32'(last_fall - last_tick), 42);
    chk("t1_data", 32'(dac_data), 32'h2A5);
    chk("t1_grant_b", 32'(grant_b), 0);
    chk("t1_sample_cnt", 32'(sample_cnt), 1);
    do_reset();
    req_a = 1; req_b = 1; data_a = 10'h100; data_b = 10'h200;
    for (int i = 0; i < 4; i++) begin
      pulse_tick();
      cyc(4);
      chk("alt_data", 32'(dac_data), 32'(alt_seq[i]));
      cyc(95);
    end
    chk("alt_overrun", 32'(overrun), 0);
    req_a = 0; req_b = 0;
    do_reset();
    req_a = 1; data_a = 10'h155;
    pulse_tick();
    cyc(9);
    pulse_tick();
    cyc(60);
    chk("ovr_flag", 32'(overrun), 1);
    chk("ovr_sample_cnt", 32'(sample_cnt), 1);
    req_a = 0;
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      cyc(4);
    end
    chk("miss_cnt3", 32'(miss_cnt), 3);
    chk("miss_data_hold", 32'(dac_data), 32'h155);
    chk("ovr_sticky", 32'(overrun), 1);
    req_a = 1; data_a = 10'h3FF;
    pulse_tick();
    cyc(19);
    reset = 1;
    cyc(1);
    reset = 0;
    req_a = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_data", 32'(dac_data), 0);
    req_b = 1; data_b = 10'h0AB;
    pulse_tick();
    cyc(3);
    chk("after_abort_grant_b", 32'(grant_b), 1);
    chk("after_abort_data", 32'(dac_data), 32'h0AB);
    req_b = 0;
    cyc(45);
    req_a = 1; reset = 1; tick = 1;
    cyc(1);
    tick = 0; reset = 0;
    cyc(2);
    chk("reset_beats_tick", 32'(busy), 0);
    req_a = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req_a = 1; data_a = 10'(i + 1);
      pulse_tick();
      cyc(1);
      req_a = 0;
      cyc(48);
    end
    for (int i = 0; i < 5; i++) begin
      pulse_tick();
      cyc(3);
    end
    chk("w2_sample_wrap", 32'(sample_cnt2), 1);
    chk("w2_miss_sat", 32'(miss_cnt2), 3);
    chk("w16_sample_cnt", 32'(sample_cnt), 5);
    chk("w16_miss_cnt", 32'(miss_cnt), 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
